// File: rtl/sn74_display_pkg.sv
// Shared definitions for the multiplexed BCD display scanner family.
// Holds FSM encodings, nibble width and the default timing constants.
package sn74_display_pkg;

  localparam int NIB_W              = 4;
  localparam int DEF_DIGITS         = 4;
  localparam int DEF_SLOT_CYCLES    = 50000;
  localparam int DEF_BLANK_CYCLES   = 16;
  localparam int DEF_DIG_ACTIVE_LOW = 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Only a true zero counts for leading-zero blanking; 10..15 are glyphs.
  function automatic logic nib_is_zero(input logic [NIB_W-1:0] nib);
    return nib == '0;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_scan_timer.sv
// Slot counter and digit index for multiplexed display drivers.
// All outputs describe the state the registers take on the coming edge.
module scan_timer
  import sn74_display_pkg::*;
#(
  parameter int DIGITS       = DEF_DIGITS,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [$clog2(DIGITS)-1:0] idx_next,
  output logic                      slot_start,
  output logic                      in_blank,
  output logic                      frame_end,
  output logic                      frame_last
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx;
  logic             wrap;
  logic             last_digit;

  assign wrap       = (cnt == CNT_W'(SLOT_CYCLES - 1));
  assign last_digit = (idx == IDX_W'(DIGITS - 1));

  // NOTE: every variable written in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_next = cnt + 1'b1;
    idx_next = idx;
    if (wrap) begin
      cnt_next = '0;
      idx_next = last_digit ? '0 : idx + 1'b1;
    end
  end

  assign slot_start = wrap;
  assign frame_end  = wrap && last_digit;
  assign in_blank   = (cnt_next < CNT_W'(BLANK_CYCLES));
  assign frame_last = (cnt_next == CNT_W'(SLOT_CYCLES - 1)) &&
                      (idx_next == IDX_W'(DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a packed multi-digit BCD value onto a 7-segment decoder,
// with per-slot dead time, tear-free frame updates and leading-zero blanking.
module bcd_display_scanner
  import sn74_display_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int SLOT_CYCLES    = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int DIG_ACTIVE_LOW = DEF_DIG_ACTIVE_LOW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIGITS*NIB_W-1:0] bcd_value,
  input  logic                    load,
  input  logic                    lzb_en,
  input  logic                    blank_all,
  output logic                    pin_a,
  output logic                    pin_b,
  output logic                    pin_c,
  output logic                    pin_d,
  output logic                    pin_bi_n,
  output logic [DIGITS-1:0]       digit_en,
  output logic                    frame_done
);

  localparam int   IDX_W   = $clog2(DIGITS);
  localparam int   VAL_W   = DIGITS * NIB_W;
  localparam logic ACT_LOW = (DIG_ACTIVE_LOW != 0);

  logic [IDX_W-1:0] idx_next;
  logic             slot_start;
  logic             in_blank;
  logic             frame_end;
  logic             frame_last;

  scan_timer #(
    .DIGITS       (DIGITS),
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_next   (idx_next),
    .slot_start (slot_start),
    .in_blank   (in_blank),
    .frame_end  (frame_end),
    .frame_last (frame_last)
  );

  scan_state_t      state_q, state_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  logic [VAL_W-1:0] pend_q;
  logic             pend_flag_q;
  logic             slot_blank_q, slot_blank_d;
  logic [DIGITS-1:0] upper_zero;
  logic             zero_run;
  logic             lz_hit;
  logic [NIB_W-1:0] nib;
  logic [DIGITS-1:0] en_onehot;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (!in_blank)  state_d = ST_SHOW;
      ST_SHOW:  if (slot_start) state_d = ST_BLANK;
    endcase
  end

  // A load on the boundary cycle itself wins over an older pending value.
  always_comb begin
    disp_d = disp_q;
    if (frame_end) begin
      if (load)             disp_d = bcd_value;
      else if (pend_flag_q) disp_d = pend_q;
    end
  end

  // upper_zero[i]: every nibble from i up to the most significant is zero.
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & nib_is_zero(disp_d[i*NIB_W +: NIB_W]);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    nib       = '0;
    lz_hit    = 1'b0;
    en_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nib          = disp_d[i*NIB_W +: NIB_W];
        lz_hit       = (i != 0) && upper_zero[i];
        en_onehot[i] = (state_d == ST_SHOW);
      end
    end
  end

  // Blanking controls are latched once per slot so a slot never changes mid-way.
  assign slot_blank_d = slot_start ? (blank_all || (lzb_en && lz_hit)) : slot_blank_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      slot_blank_q <= 1'b0;
      pin_a        <= 1'b0;
      pin_b        <= 1'b0;
      pin_c        <= 1'b0;
      pin_d        <= 1'b0;
      pin_bi_n     <= 1'b0;
      digit_en     <= {DIGITS{ACT_LOW}};
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_q       <= disp_d;
      slot_blank_q <= slot_blank_d;
      if (frame_end) begin
        pend_flag_q <= 1'b0;
      end else if (load) begin
        pend_q      <= bcd_value;
        pend_flag_q <= 1'b1;
      end
      pin_a      <= nib[0];
      pin_b      <= nib[1];
      pin_c      <= nib[2];
      pin_d      <= nib[3];
      pin_bi_n   <= (state_d == ST_SHOW) && !slot_blank_d;
      digit_en   <= en_onehot ^ {DIGITS{ACT_LOW}};
      frame_done <= frame_last;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed scoreboard bench for bcd_display_scanner (4 digits, 8-cycle slots).
// Expected per-slot results are queued as stimulus is applied and popped as each slot is observed.
module tb_bcd_display_scanner;

  localparam int DIGITS = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_value;
  logic        load;
  logic        lzb_en;
  logic        blank_all;
  logic        pin_a, pin_b, pin_c, pin_d;
  logic        pin_bi_n;
  logic [3:0]  digit_en;
  logic        frame_done;

  bcd_display_scanner #(
    .DIGITS         (DIGITS),
    .SLOT_CYCLES    (SLOT),
    .BLANK_CYCLES   (BLANK),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_value  (bcd_value),
    .load       (load),
    .lzb_en     (lzb_en),
    .blank_all  (blank_all),
    .pin_a      (pin_a),
    .pin_b      (pin_b),
    .pin_c      (pin_c),
    .pin_d      (pin_d),
    .pin_bi_n   (pin_bi_n),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nib;
    logic       lit;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;  // edges since the last reset release

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic advance_to(input int t);
    while (k < t) begin
      @(posedge clk);
      k++;
      #1;
    end
  endtask

  task automatic do_load(input int edge_no, input logic [15:0] v);
    advance_to(edge_no - 1);
    bcd_value = v;
    load      = 1'b1;
    advance_to(edge_no);
    load      = 1'b0;
  endtask

  // lit[i] = 1 when digit i is expected unblanked during SHOW.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] lit);
    exp_t e;
    for (int i = 0; i < DIGITS; i++) begin
      e.nib = v[i*4 +: 4];
      e.lit = lit[i];
      sb.push_back(e);
    end
  endtask

  task automatic check_slot(input int f, input int i);
    int         base;
    exp_t       e;
    logic [3:0] sel;
    string      t;
    base = f * FRAME + i * SLOT;
    t    = $sformatf("f%0d_d%0d", f, i);
    check({t, "_sb_has_entry"}, (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e   = sb.pop_front();
    sel = ~(4'b0001 << i);
    advance_to(base);
    @(negedge clk);
    check({t, "_dead_en"},  digit_en, 4'hF);
    check({t, "_dead_bi"},  pin_bi_n, 1'b0);
    check({t, "_dead_nib"}, {pin_d, pin_c, pin_b, pin_a}, e.nib);
    check({t, "_dead_fd"},  frame_done, 1'b0);
    advance_to(base + 1);
    @(negedge clk);
    check({t, "_dead2_en"}, digit_en, 4'hF);
    advance_to(base + BLANK);
    @(negedge clk);
    check({t, "_show_en"},  digit_en, sel);
    check({t, "_show_nib"}, {pin_d, pin_c, pin_b, pin_a}, e.nib);
    check({t, "_show_bi"},  pin_bi_n, e.lit);
    if (i == DIGITS - 1) begin
      advance_to(base + SLOT - 2);
      @(negedge clk);
      check({t, "_fd_early"}, frame_done, 1'b0);
      advance_to(base + SLOT - 1);
      @(negedge clk);
      check({t, "_fd_pulse"}, frame_done, 1'b1);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, "_en"},  digit_en, 4'hF);
    check({t, "_bi"},  pin_bi_n, 1'b0);
    check({t, "_nib"}, {pin_d, pin_c, pin_b, pin_a}, 4'h0);
    check({t, "_fd"},  frame_done, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    bcd_value = 16'h0000;
    lzb_en    = 1'b0;
    blank_all = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;

    // Frame 0: reset value; a load in digit 1's slot must not tear this frame.
    push_frame(16'h0000, 4'b1111);
    check_slot(0, 0);
    check_slot(0, 1);
    do_load(11, 16'h1234);
    check_slot(0, 2);
    check_slot(0, 3);

    // Frame 1: 1234 appears; enable leading-zero blanking and queue 0070.
    push_frame(16'h1234, 4'b1111);
    check_slot(1, 0);
    lzb_en = 1'b1;
    do_load(38, 16'h0070);
    for (int i = 1; i < DIGITS; i++) check_slot(1, i);

    // Frame 2: 0070 with LZB -> digits 3,2 dark.
    push_frame(16'h0070, 4'b0011);
    check_slot(2, 0);
    do_load(70, 16'h0000);
    for (int i = 1; i < DIGITS; i++) check_slot(2, i);

    // Frame 3: all zero -> only digit 0 lit.
    push_frame(16'h0000, 4'b0001);
    check_slot(3, 0);
    do_load(102, 16'h1000);
    for (int i = 1; i < DIGITS; i++) check_slot(3, i);

    // Frame 4: 1000 -> all lit; two loads in one frame, last wins.
    push_frame(16'h1000, 4'b1111);
    check_slot(4, 0);
    lzb_en = 1'b0;
    do_load(133, 16'h5555);
    check_slot(4, 1);
    do_load(141, 16'h9999);
    check_slot(4, 2);
    check_slot(4, 3);

    // Frame 5: 9999; a pending 7777 is overridden by a load on the boundary edge.
    push_frame(16'h9999, 4'b1111);
    check_slot(5, 0);
    do_load(165, 16'h7777);
    for (int i = 1; i < DIGITS; i++) check_slot(5, i);
    do_load(6 * FRAME, 16'h0A68);

    // Frame 6: 0A68 shown at once; blank_all raised mid-slot of digit 1.
    push_frame(16'h0A68, 4'b0011);
    check_slot(6, 0);
    check_slot(6, 1);
    blank_all = 1'b1;
    advance_to(6 * FRAME + SLOT + 5);
    @(negedge clk);
    check("f6_d1_blank_all_late_bi", pin_bi_n, 1'b1);
    check("f6_d1_blank_all_late_en", digit_en, 4'b1101);
    check_slot(6, 2);
    check_slot(6, 3);
    blank_all = 1'b0;

    // Frame 7: display restored; stale pending 7777 must not appear.
    push_frame(16'h0A68, 4'b1111);
    for (int i = 0; i < DIGITS; i++) check_slot(7, i);

    // Frame 8: pending load, then reset during digit 2's SHOW.
    do_load(8 * FRAME + 4, 16'h8888);
    advance_to(8 * FRAME + 2 * SLOT + 2);
    @(negedge clk);
    check("pre_reset_nib", {pin_d, pin_c, pin_b, pin_a}, 4'hA);
    check("pre_reset_en",  digit_en, 4'b1011);
    rst_n = 1'b0;
    advance_to(8 * FRAME + 2 * SLOT + 3);
    @(negedge clk);
    check_reset("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;

    // After release: scan restarts from digit 0 with zero, pending discarded.
    push_frame(16'h0000, 4'b1111);
    push_frame(16'h0000, 4'b1111);
    for (int i = 0; i < DIGITS; i++) check_slot(0, i);
    for (int i = 0; i < DIGITS; i++) check_slot(1, i);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
